// File: rtl/seg_count_ctrl.sv
// seg_count_ctrl: key debounce, start/run/pause FSM, tick prescaler
// and a two-digit time-multiplexed seven-segment driver.
module seg_count_ctrl #(
    parameter int TICK_DIV = 50000000,
    parameter int SCAN_DIV = 50000,
    parameter int DEB_CNT  = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_start_n,
    input  logic       key_clr_n,
    input  logic [3:0] data_0,
    input  logic [3:0] data_1,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic       run,
    output logic [6:0] seg,
    output logic [1:0] sel
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEB_CNT + 1);

    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CNT - 1);

    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // bit 0 = start key, bit 1 = clear key
    logic [1:0]         w_key_raw;
    logic [1:0]         r_sync1;
    logic [1:0]         r_sync2;
    logic [1:0]         r_deb;
    logic [1:0]         r_press;
    logic [1:0][DW-1:0] r_deb_cnt;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [TW-1:0]      r_presc;
    logic               w_run_hold;
    logic               w_wrap;
    logic               w_tick;
    logic               r_cnt_en;
    logic               r_cnt_clr;
    logic               r_run;

    logic [SW-1:0]      r_scan;
    logic               r_idx;
    logic [3:0]         w_digit;
    logic [6:0]         w_seg_nxt;
    logic [1:0]         w_sel_nxt;
    logic [6:0]         r_seg;
    logic [1:0]         r_sel;

    assign w_key_raw = {key_clr_n, key_start_n};

    // A level change is accepted after DEB_CNT consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 2'b11;
            r_sync2   <= 2'b11;
            r_deb     <= 2'b11;
            r_press   <= 2'b00;
            r_deb_cnt <= '0;
        end else begin
            r_sync1 <= w_key_raw;
            r_sync2 <= r_sync1;
            for (int k = 0; k < 2; k++) begin
                r_press[k] <= 1'b0;
                if (r_sync2[k] == r_deb[k]) begin
                    r_deb_cnt[k] <= '0;
                end else if (r_deb_cnt[k] == DEB_LAST) begin
                    r_deb_cnt[k] <= '0;
                    r_deb[k]     <= r_sync2[k];
                    r_press[k]   <= ~r_sync2[k];
                end else begin
                    r_deb_cnt[k] <= r_deb_cnt[k] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Clear has priority over a simultaneous start press.
    always_comb begin
        w_state_nxt = r_state;
        if (r_press[1]) begin
            w_state_nxt = ST_IDLE;
        end else if (r_press[0]) begin
            unique case (r_state)
                ST_IDLE:  w_state_nxt = ST_RUN;
                ST_RUN:   w_state_nxt = ST_PAUSE;
                ST_PAUSE: w_state_nxt = ST_RUN;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign w_run_hold = (r_state == ST_RUN) && (w_state_nxt == ST_RUN);
    assign w_wrap     = (r_presc == TICK_MAX);
    assign w_tick     = w_run_hold && w_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_state_nxt == ST_IDLE) begin
            r_presc <= '0;
        end else if (w_run_hold) begin
            r_presc <= w_wrap ? '0 : r_presc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_en  <= 1'b0;
            r_cnt_clr <= 1'b0;
            r_run     <= 1'b0;
        end else begin
            r_cnt_en  <= w_tick;
            r_cnt_clr <= r_press[1];
            r_run     <= (w_state_nxt == ST_RUN);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan <= '0;
            r_idx  <= 1'b0;
        end else if (r_scan == SCAN_MAX) begin
            r_scan <= '0;
            r_idx  <= ~r_idx;
        end else begin
            r_scan <= r_scan + 1'b1;
        end
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    // Tens digit is blanked when zero, but its select stays driven.
    always_comb begin
        w_digit   = r_idx ? data_1 : data_0;
        w_sel_nxt = r_idx ? 2'b01 : 2'b10;
        w_seg_nxt = seg_decode(w_digit);
        if (r_idx && (data_1 == 4'd0)) begin
            w_seg_nxt = SEG_OFF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= SEG_OFF;
            r_sel <= 2'b10;
        end else begin
            r_seg <= w_seg_nxt;
            r_sel <= w_sel_nxt;
        end
    end

    assign cnt_en  = r_cnt_en;
    assign cnt_clr = r_cnt_clr;
    assign run     = r_run;
    assign seg     = r_seg;
    assign sel     = r_sel;

endmodule

// File: tb/tb_seg_count_ctrl.sv
// tb_seg_count_ctrl: directed scenarios plus random key/data traffic,
// each cycle compared against an event-level reference model.
module tb_seg_count_ctrl;

    localparam int TICK = 4;
    localparam int SCAN = 3;
    localparam int DEB  = 2;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;

    localparam logic [6:0] DEC [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
        7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
    };

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       key_start_n = 1'b1;
    logic       key_clr_n = 1'b1;
    logic [3:0] data_0 = 4'd0;
    logic [3:0] data_1 = 4'd0;
    logic       cnt_en;
    logic       cnt_clr;
    logic       run;
    logic [6:0] seg;
    logic [1:0] sel;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seg_count_ctrl #(
        .TICK_DIV(TICK),
        .SCAN_DIV(SCAN),
        .DEB_CNT (DEB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_start_n(key_start_n),
        .key_clr_n  (key_clr_n),
        .data_0     (data_0),
        .data_1     (data_1),
        .cnt_en     (cnt_en),
        .cnt_clr    (cnt_clr),
        .run        (run),
        .seg        (seg),
        .sel        (sel)
    );

    // Reference model: raw key history, press events, run-cycle count,
    // and edge count since reset for the scan slot.
    bit         q_start[$];
    bit         q_clr[$];
    bit         m_lvl_start;
    bit         m_lvl_clr;
    bit         m_ps;
    bit         m_pc;
    int         m_state;
    int         m_run_cyc;
    int         m_t;
    logic       m_run;
    logic       m_en;
    logic       m_clr;
    logic [6:0] m_seg;
    logic [1:0] m_sel;

    // True when the last DEB synchronized samples all differ from lvl.
    function automatic bit settled(input bit q[$], input bit lvl);
        for (int i = 0; i < DEB; i++) begin
            if (q[q.size() - 3 - i] == lvl) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        q_start.delete();
        q_clr.delete();
        for (int i = 0; i < DEB + 2; i++) begin
            q_start.push_back(1'b1);
            q_clr.push_back(1'b1);
        end
        m_lvl_start = 1'b1;
        m_lvl_clr   = 1'b1;
        m_ps        = 1'b0;
        m_pc        = 1'b0;
        m_state     = M_IDLE;
        m_run_cyc   = 0;
        m_t         = 0;
        m_run       = 1'b0;
        m_en        = 1'b0;
        m_clr       = 1'b0;
        m_seg       = 7'b1111111;
        m_sel       = 2'b10;
    endtask

    task automatic model_edge();
        int nst;
        int idx;
        nst   = m_state;
        m_en  = 1'b0;
        m_clr = 1'b0;
        if (m_pc) begin
            nst   = M_IDLE;
            m_clr = 1'b1;
        end else if (m_ps) begin
            nst = (m_state == M_RUN) ? M_PAUSE : M_RUN;
        end
        if (m_state == M_RUN && nst == M_RUN) begin
            m_run_cyc++;
            m_en = (m_run_cyc % TICK == 0);
        end
        if (nst == M_IDLE) m_run_cyc = 0;
        m_state = nst;
        m_run   = (nst == M_RUN);
        q_start.push_back(key_start_n);
        q_clr.push_back(key_clr_n);
        if (q_start.size() > 32) void'(q_start.pop_front());
        if (q_clr.size() > 32) void'(q_clr.pop_front());
        m_ps = 1'b0;
        m_pc = 1'b0;
        if (settled(q_start, m_lvl_start)) begin
            m_lvl_start = !m_lvl_start;
            m_ps        = !m_lvl_start;
        end
        if (settled(q_clr, m_lvl_clr)) begin
            m_lvl_clr = !m_lvl_clr;
            m_pc      = !m_lvl_clr;
        end
        m_t++;
        idx   = ((m_t - 1) / SCAN) % 2;
        m_sel = (idx == 1) ? 2'b01 : 2'b10;
        if (idx == 1) m_seg = (data_1 == 4'd0) ? 7'b1111111 : DEC[data_1];
        else          m_seg = DEC[data_0];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h t=%0d", tag, obs, exp, m_t);
        end
    endtask

    task automatic check_all();
        chk("run", 32'(run), 32'(m_run));
        chk("cnt_en", 32'(cnt_en), 32'(m_en));
        chk("cnt_clr", 32'(cnt_clr), 32'(m_clr));
        chk("sel", 32'(sel), 32'(m_sel));
        chk("seg", 32'(seg), 32'(m_seg));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic apply_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_seg", 32'(seg), 32'h7f);
        chk("rst_sel", 32'(sel), 32'h2);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int         lat;
        int         gap;
        int         n;
        int         n2;
        logic       prev_run;
        logic [1:0] prev_sel;

        // 1: idle after reset, scan alternates, tens blanked
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        prev_sel = sel;
        for (int i = 0; i < 20; i++) begin
            step();
            if (sel !== prev_sel) n++;
            prev_sel = sel;
        end
        chk("sel_toggles", 32'(n), 32'd6);

        // 2: start press, run latency and single entry
        key_start_n = 1'b0;
        lat = 0;
        n = 0;
        prev_run = run;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) key_start_n = 1'b1;
            step();
            if (run && !prev_run) n++;
            if (run && lat == 0) lat = i + 1;
            prev_run = run;
        end
        chk("start_latency", 32'(lat), 32'd5);
        chk("run_entries", 32'(n), 32'd1);

        // 3: clear to idle, then bounced start press
        key_clr_n = 1'b0;
        n2 = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 6) key_clr_n = 1'b1;
            step();
            if (cnt_clr) n2++;
        end
        chk("clr_pulses", 32'(n2), 32'd1);
        n = 0;
        prev_run = run;
        for (int i = 0; i < 14; i++) begin
            key_start_n = (i < 4) ? 1'(i % 2) : 1'b0;
            step();
            if (run && !prev_run) n++;
            prev_run = run;
        end
        chk("bounce_entries", 32'(n), 32'd1);
        key_start_n = 1'b1;
        repeat (6) step();

        // 4: pause with prescaler at 2, then resume
        n = 0;
        while (m_run_cyc % TICK != 2 && n < 2 * TICK) begin
            step();
            n++;
        end
        chk("align_bound", 32'(m_run_cyc % TICK), 32'd2);
        key_start_n = 1'b0;
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (!run && lat == 0) lat = i + 1;
        end
        chk("pause_latency", 32'(lat), 32'd5);
        key_start_n = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (cnt_en) n++;
        end
        chk("pause_no_en", 32'(n), 32'd0);
        key_start_n = 1'b0;
        lat = 0;
        gap = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (run && lat == 0) lat = i + 1;
            if (cnt_en && gap == 0 && lat != 0) gap = i + 1 - lat;
        end
        chk("resume_gap", 32'(gap), 32'd2);
        key_start_n = 1'b1;
        repeat (6) step();

        // 5: start and clear pressed together from RUN
        key_start_n = 1'b0;
        key_clr_n = 1'b0;
        n = 0;
        n2 = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (cnt_clr) n2++;
            if (cnt_en && n2 != 0) n++;
        end
        chk("both_clr", 32'(n2), 32'd1);
        chk("both_no_en", 32'(n), 32'd0);
        chk("both_idle", 32'(run), 32'd0);
        key_start_n = 1'b1;
        key_clr_n = 1'b1;
        repeat (8) step();

        // 6: digit decode, dash, and reset mid-scan
        data_1 = 4'd1;
        data_0 = 4'd5;
        for (int i = 0; i < 6; i++) begin
            step();
            if (m_sel == 2'b10) chk("ones_5", 32'(seg), 32'b0010010);
            else                chk("tens_1", 32'(seg), 32'b1111001);
        end
        data_0 = 4'd12;
        for (int i = 0; i < 6; i++) begin
            step();
            if (m_sel == 2'b10) chk("ones_dash", 32'(seg), 32'b0111111);
            else                chk("tens_1b", 32'(seg), 32'b1111001);
        end
        step();
        apply_reset();

        // random key and data traffic
        for (int s = 0; s < 90; s++) begin
            key_start_n = 1'($urandom_range(0, 1));
            key_clr_n = ($urandom_range(0, 5) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 1) == 1) begin
                data_0 = 4'($urandom_range(0, 15));
                data_1 = 4'($urandom_range(0, 15));
            end
            n = $urandom_range(1, 7);
            for (int i = 0; i < n; i++) step();
            if (s == 60) apply_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
